// File: rtl/pad_poll_scheduler.sv
// Polls the two-player pad word every div+1 vblank rises, debounces it and keeps sticky press/release edges.
// STATE lands 3 clocks after the vblank rise is registered; rdata is 1 clock after the strobe; no backpressure, a rise outside IDLE is dropped.
module pad_poll_scheduler #(
    parameter int DEBOUNCE = 2,
    parameter int FRAME_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vblank,
    input  logic [31:0] pad_raw,
    input  logic        addr_match,
    input  logic        read_stb,
    input  logic        write_stb,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        COMPARE = 2'd2,
        UPDATE  = 2'd3
    } fsm_t;

    localparam logic [FRAME_W-1:0] POLL_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

    fsm_t               fsm;
    logic               vblank_q;
    logic [31:0]        hist [DEBOUNCE];
    logic [31:0]        new_state;
    logic [31:0]        state;
    logic [31:0]        pressed;
    logic [31:0]        released;
    logic [FRAME_W-1:0] pollcnt;
    logic [3:0]         divcnt;
    logic               ctrl_en;
    logic               ctrl_irq_en;
    logic [3:0]         ctrl_div;

    logic               vb_rise;
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        clr_pressed;
    logic [31:0]        clr_released;
    logic [31:0]        set_pressed;
    logic [31:0]        set_released;
    logic [31:0]        stable1;
    logic [31:0]        stable0;
    logic [31:0]        stable_state;
    logic [31:0]        ctrl_word;
    logic [31:0]        pollcnt_ext;
    logic [31:0]        rd_mux;

    assign vb_rise     = vblank & ~vblank_q;
    // A simultaneous write suppresses the read, including its read-to-clear side effect.
    assign rd_en       = addr_match & read_stb & ~write_stb;
    assign wr_en       = addr_match & write_stb;
    assign ctrl_word   = {24'h0, ctrl_div, 2'b00, ctrl_irq_en, ctrl_en};
    assign pollcnt_ext = 32'(pollcnt);

    always_comb begin
        stable1 = '1;
        stable0 = '1;
        for (int i = 0; i < DEBOUNCE; i++) begin
            stable1 = stable1 & hist[i];
            stable0 = stable0 & ~hist[i];
        end
        stable_state = stable1 | (state & ~stable0);
    end

    always_comb begin
        clr_pressed  = '0;
        clr_released = '0;
        if (rd_en && addr == 3'd1) clr_pressed = '1;
        else if (wr_en && addr == 3'd1) clr_pressed = wdata;
        if (rd_en && addr == 3'd2) clr_released = '1;
        else if (wr_en && addr == 3'd2) clr_released = wdata;
        set_pressed  = '0;
        set_released = '0;
        if (fsm == UPDATE) begin
            set_pressed  = new_state & ~state;
            set_released = ~new_state & state;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            3'd0:    rd_mux = state;
            3'd1:    rd_mux = pressed;
            3'd2:    rd_mux = released;
            3'd3:    rd_mux = ctrl_word;
            3'd4:    rd_mux = pollcnt_ext;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm         <= IDLE;
            vblank_q    <= 1'b0;
            for (int i = 0; i < DEBOUNCE; i++) hist[i] <= '0;
            new_state   <= '0;
            state       <= '0;
            pressed     <= '0;
            released    <= '0;
            pollcnt     <= '0;
            divcnt      <= '0;
            ctrl_en     <= 1'b1;
            ctrl_irq_en <= 1'b0;
            ctrl_div    <= '0;
            rdata       <= '0;
            irq         <= 1'b0;
        end else begin
            vblank_q <= vblank;
            rdata    <= rd_en ? rd_mux : '0;
            irq      <= ctrl_irq_en & ((|pressed) | (|released));
            // Set wins over a same-cycle clear so a fresh edge is never lost.
            pressed  <= (pressed & ~clr_pressed) | set_pressed;
            released <= (released & ~clr_released) | set_released;

            case (fsm)
                IDLE: begin
                    if (vb_rise && ctrl_en) begin
                        if (divcnt == ctrl_div) begin
                            divcnt <= '0;
                            fsm    <= SAMPLE;
                        end else begin
                            divcnt <= divcnt + 4'd1;
                        end
                    end
                end
                SAMPLE: begin
                    hist[0] <= pad_raw;
                    for (int i = 1; i < DEBOUNCE; i++) hist[i] <= hist[i-1];
                    fsm <= COMPARE;
                end
                COMPARE: begin
                    new_state <= stable_state;
                    fsm       <= UPDATE;
                end
                UPDATE: begin
                    state   <= new_state;
                    pollcnt <= pollcnt + POLL_ONE;
                    fsm     <= IDLE;
                end
                default: fsm <= IDLE;
            endcase

            if (wr_en && addr == 3'd3) begin
                ctrl_en     <= wdata[0];
                ctrl_irq_en <= wdata[1];
                ctrl_div    <= wdata[7:4];
                divcnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pad_poll_scheduler.sv
// Directed bench for pad_poll_scheduler: hand-computed register values after each poll sequence.
module tb_pad_poll_scheduler;

    logic        clk;
    logic        reset_n;
    logic        vblank;
    logic [31:0] pad_raw;
    logic        addr_match;
    logic        read_stb;
    logic        write_stb;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    pad_poll_scheduler #(.DEBOUNCE(2), .FRAME_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vblank     (vblank),
        .pad_raw    (pad_raw),
        .addr_match (addr_match),
        .read_stb   (read_stb),
        .write_stb  (write_stb),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        addr       = a;
        addr_match = 1'b1;
        read_stb   = 1'b1;
        tick();
        addr_match = 1'b0;
        read_stb   = 1'b0;
        d          = rdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr       = a;
        wdata      = d;
        addr_match = 1'b1;
        write_stb  = 1'b1;
        tick();
        addr_match = 1'b0;
        write_stb  = 1'b0;
    endtask

    task automatic poll();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        logic [31:0] d;
        reset_n    = 1'b0;
        vblank     = 1'b0;
        pad_raw    = '0;
        addr_match = 1'b0;
        read_stb   = 1'b0;
        write_stb  = 1'b0;
        addr       = '0;
        wdata      = '0;
        repeat (3) tick();
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        tick();

        rd(3'd0, d); check("rst_state", d, 32'h0);
        rd(3'd3, d); check("rst_ctrl", d, 32'h1);
        rd(3'd4, d); check("rst_pollcnt", d, 32'h0);
        tick();
        check("idle_rdata", rdata, 32'h0);
        check("idle_irq", {31'h0, irq}, 32'h0);
        rd(3'd5, d); check("addr5_zero", d, 32'h0);

        // Press bit 3: first poll leaves it unstable, second poll latches it.
        pad_raw = 32'h0000_0008;
        poll();
        rd(3'd0, d); check("press_one_sample", d, 32'h0);
        poll();
        rd(3'd0, d); check("press_state", d, 32'h8);
        rd(3'd1, d); check("press_pressed", d, 32'h8);
        rd(3'd1, d); check("press_rtc", d, 32'h0);
        check("press_irq_masked", {31'h0, irq}, 32'h0);
        rd(3'd4, d); check("pollcnt_2", d, 32'h2);

        pad_raw = 32'h0;
        poll();
        poll();
        rd(3'd0, d); check("release_state", d, 32'h0);
        rd(3'd2, d); check("release_released", d, 32'h8);

        // Single-poll glitch on bit 16 never reaches STATE.
        pad_raw = 32'h0001_0000;
        poll();
        pad_raw = 32'h0;
        poll();
        poll();
        rd(3'd0, d); check("glitch_state", d, 32'h0);
        rd(3'd1, d); check("glitch_pressed", d, 32'h0);
        rd(3'd4, d); check("pollcnt_7", d, 32'h7);

        // Simultaneous read and write: write lands, read data is zero.
        addr = 3'd3; wdata = 32'h0000_0013;
        addr_match = 1'b1; read_stb = 1'b1; write_stb = 1'b1;
        tick();
        addr_match = 1'b0; read_stb = 1'b0; write_stb = 1'b0;
        check("rdwr_rdata", rdata, 32'h0);
        rd(3'd3, d); check("rdwr_ctrl", d, 32'h13);

        wr(3'd3, 32'hFFFF_FF32);
        rd(3'd3, d); check("ctrl_masked", d, 32'h32);
        poll();
        poll();
        rd(3'd4, d); check("disabled_no_poll", d, 32'h7);
        wr(3'd0, 32'hFFFF_FFFF);
        rd(3'd0, d); check("state_not_writable", d, 32'h0);

        // div=3: polls on the 4th and 8th rise.
        pad_raw = 32'h0000_0004;
        wr(3'd3, 32'h0000_0033);
        repeat (3) poll();
        rd(3'd4, d); check("div3_after3", d, 32'h7);
        poll();
        rd(3'd4, d); check("div3_after4", d, 32'h8);
        repeat (4) poll();
        rd(3'd4, d); check("div3_after8", d, 32'h9);
        rd(3'd0, d); check("div3_state", d, 32'h4);
        check("irq_on_press", {31'h0, irq}, 32'h1);
        rd(3'd1, d); check("div3_pressed", d, 32'h4);
        tick();
        check("irq_off_after_rtc", {31'h0, irq}, 32'h0);

        wr(3'd3, 32'h0000_0003);
        pad_raw = 32'h0;
        poll();
        poll();
        rd(3'd0, d); check("rel2_state", d, 32'h0);
        check("irq_on_release", {31'h0, irq}, 32'h1);
        wr(3'd2, 32'h0000_0004);
        check("irq_still_at_w1c", {31'h0, irq}, 32'h1);
        tick();
        check("irq_off_after_w1c", {31'h0, irq}, 32'h0);
        rd(3'd2, d); check("w1c_released", d, 32'h0);

        // Read-to-clear coinciding with UPDATE that sets bit 4.
        pad_raw = 32'h0000_0001;
        poll();
        poll();
        pad_raw = 32'h0000_0011;
        poll();
        rd(3'd0, d); check("pre_coinc_state", d, 32'h1);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
        tick();
        addr = 3'd1; addr_match = 1'b1; read_stb = 1'b1;
        tick();
        addr_match = 1'b0; read_stb = 1'b0;
        check("coinc_read", rdata, 32'h1);
        rd(3'd1, d); check("coinc_pressed_after", d, 32'h10);
        rd(3'd0, d); check("coinc_state", d, 32'h11);

        // Reset in COMPARE with buttons held.
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("midpoll_rst_irq", {31'h0, irq}, 32'h0);
        check("midpoll_rst_rdata", rdata, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        rd(3'd0, d); check("post_rst_state", d, 32'h0);
        rd(3'd1, d); check("post_rst_pressed", d, 32'h0);
        rd(3'd4, d); check("post_rst_pollcnt", d, 32'h0);
        rd(3'd3, d); check("post_rst_ctrl", d, 32'h1);
        poll();
        rd(3'd0, d); check("post_rst_poll1", d, 32'h0);
        poll();
        rd(3'd0, d); check("post_rst_poll2", d, 32'h11);
        rd(3'd1, d); check("post_rst_pressed2", d, 32'h11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
